// File: rtl/ahb_rr_burst_arbiter.sv
// ahb_rr_burst_arbiter: round-robin, burst-aware AHB slave-port arbiter with zero-bubble handover
module ahb_rr_burst_arbiter #(
    parameter int MASTER_NUM     = 4,
    parameter int MAX_INCR_BEATS = 16
) (
    input  logic                          hclk,
    input  logic                          hreset_n,
    input  logic [MASTER_NUM-1:0]         hreq,
    input  logic [3*MASTER_NUM-1:0]       hburst,
    input  logic                          hready,
    output logic [MASTER_NUM-1:0]         hgrant,
    output logic [$clog2(MASTER_NUM)-1:0] hmaster,
    output logic                          hsel,
    output logic                          hlast,
    output logic                          busy
);
    localparam int MW = $clog2(MASTER_NUM);
    localparam int CW = $clog2(MAX_INCR_BEATS) + 1;
    localparam int LW = CW > 5 ? CW : 5;
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_n;
    logic [MW-1:0] ptr, ptr_n, base, win, idx, master_n;
    logic [MASTER_NUM-1:0] grant_n;
    logic [LW-1:0] cnt, cnt_n, limit, limit_n, win_limit;
    logic [2:0] win_burst;
    logic found;
    // limit == 0 marks an undefined-length INCR burst
    assign hlast = (state == BURST) && hready &&
                   ((limit == '0) ? (!hreq[hmaster] || cnt == LW'(MAX_INCR_BEATS - 1))
                                  : (cnt == limit - LW'(1)));
    assign hsel  = |hgrant;
    assign busy  = (state == BURST);
    assign base  = hlast ? hmaster : ptr;
    always_comb begin
        found = 1'b0;
        win   = base;
        idx   = '0;
        for (int i = 1; i <= MASTER_NUM; i++) begin
            idx = MW'((int'(base) + i) % MASTER_NUM);
            if (!found && hreq[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end
    always_comb begin
        win_burst = '0;
        for (int k = 0; k < MASTER_NUM; k++)
            if (MW'(k) == win) win_burst = hburst[3*k +: 3];
        win_limit = win_burst == 3'd0 ? LW'(1) :
                    win_burst == 3'd1 ? '0 :
                    win_burst <  3'd4 ? LW'(4) :
                    win_burst <  3'd6 ? LW'(8) : LW'(16);
    end
    always_comb begin
        state_n  = state;
        grant_n  = hgrant;
        master_n = hmaster;
        cnt_n    = cnt;
        limit_n  = limit;
        ptr_n    = ptr;
        if (state == IDLE || hlast) begin
            if (hlast) ptr_n = hmaster;
            if (found) begin
                state_n  = BURST;
                grant_n  = MASTER_NUM'(1) << win;
                master_n = win;
                cnt_n    = '0;
                limit_n  = win_limit;
            end else begin
                state_n = IDLE;
                grant_n = '0;
                cnt_n   = '0;
            end
        end else if (hready) begin
            cnt_n = cnt + LW'(1);
        end
    end
    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state   <= IDLE;
            hgrant  <= '0;
            hmaster <= '0;
            cnt     <= '0;
            limit   <= '0;
            ptr     <= MW'(MASTER_NUM - 1);
        end else begin
            state   <= state_n;
            hgrant  <= grant_n;
            hmaster <= master_n;
            cnt     <= cnt_n;
            limit   <= limit_n;
            ptr     <= ptr_n;
        end
    end
endmodule

// File: tb/tb_ahb_rr_burst_arbiter.sv
// tb_ahb_rr_burst_arbiter: directed bursts, expected ownership records checked by a monitor at each hlast
module tb_ahb_rr_burst_arbiter;
    logic        hclk = 1'b0;
    logic        hreset_n;
    logic [3:0]  hreq;
    logic [11:0] hburst;
    logic        hready;
    logic [3:0]  hgrant;
    logic [1:0]  hmaster;
    logic        hsel, hlast, busy;
    typedef struct {int m; int cyc; bit b2b;} exp_t;
    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    ahb_rr_burst_arbiter #(.MASTER_NUM(4), .MAX_INCR_BEATS(16)) dut (
        .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .hburst(hburst), .hready(hready),
        .hgrant(hgrant), .hmaster(hmaster), .hsel(hsel), .hlast(hlast), .busy(busy)
    );
    always #5 hclk = ~hclk;
    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask
    task automatic push(input int m, input int cyc, input bit b2b);
        exp_t e;
        e.m = m; e.cyc = cyc; e.b2b = b2b;
        exp_q.push_back(e);
    endtask
    task automatic idle_chk(input string name);
        chk({name, "_hgrant"}, int'(hgrant), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask
    // Monitor: measures each ownership period and checks it when hlast fires
    int cyc = 0;
    bit b2b = 1'b0, prev_last = 1'b0;
    always @(negedge hclk) begin
        exp_t e;
        if (hsel !== 1'b1) cyc = 0;
        else begin
            if (cyc == 0) b2b = prev_last;
            cyc++;
            if (hlast === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_burst", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("burst_master", int'(hmaster), e.m);
                    chk("burst_grant", int'(hgrant), 1 << e.m);
                    chk("burst_cycles", cyc, e.cyc);
                    chk("burst_no_bubble", int'(b2b), int'(e.b2b));
                    chk("burst_busy", int'(busy), 1);
                end
                cyc = 0;
            end
        end
        prev_last = (hlast === 1'b1);
    end
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end
    initial begin
        hreset_n = 1'b0; hreq = '0; hburst = '0; hready = 1'b1;
        step(2);
        chk("rst_hgrant", int'(hgrant), 0);
        chk("rst_hmaster", int'(hmaster), 0);
        chk("rst_hsel", int'(hsel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_hlast", int'(hlast), 0);
        hreset_n = 1'b1;
        // single beat, then idle
        push(0, 1, 0);
        hreq = 4'b0001;
        step(1);
        hreq = '0;
        step(1);
        idle_chk("single_idle");
        // fresh pointer, four INCR4 requesters rotate without gaps
        hreset_n = 1'b0;
        step(1);
        hreset_n = 1'b1;
        hburst = {3'd3, 3'd3, 3'd3, 3'd3};
        push(0, 4, 0); push(1, 4, 1); push(2, 4, 1); push(3, 4, 1); push(0, 4, 1);
        hreq = 4'b1111;
        step(1);
        step(17);
        hreq = '0;
        step(3);
        idle_chk("rr_idle");
        // WRAP8 with two wait states, owner drops request early
        hburst = {3'd0, 3'd0, 3'd4, 3'd0};
        push(1, 10, 0);
        hreq = 4'b0010;
        step(1);
        for (int c = 1; c <= 10; c++) begin
            hready = (c == 3 || c == 6) ? 1'b0 : 1'b1;
            hreq = (c >= 2) ? 4'b0000 : 4'b0010;
            step(1);
        end
        hready = 1'b1;
        idle_chk("wrap8_idle");
        // INCR capped at 16 beats, then m3 takes over immediately
        hburst = {3'd0, 3'd1, 3'd0, 3'd0};
        push(2, 16, 0); push(3, 1, 1);
        hreq = 4'b1100;
        step(1);
        step(16);
        hreq = '0;
        step(2);
        idle_chk("incr_cap_idle");
        // INCR ended by request drop on beat 6
        hburst = {3'd0, 3'd0, 3'd0, 3'd1};
        push(0, 6, 0);
        hreq = 4'b0001;
        step(1);
        step(5);
        hreq = '0;
        step(1);
        idle_chk("incr_drop_idle");
        // reset in the middle of INCR16, m0 regains priority over pending m3
        hburst = {3'd0, 3'd0, 3'd0, 3'd7};
        hreq = 4'b0001;
        step(1);
        hreq = 4'b1001;
        step(6);
        hreset_n = 1'b0;
        step(1);
        idle_chk("midrst");
        chk("midrst_hsel", int'(hsel), 0);
        hreset_n = 1'b1;
        push(0, 16, 0); push(3, 1, 1);
        step(1);
        step(16);
        hreq = '0;
        step(2);
        idle_chk("post_rst_idle");
        step(2);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
